// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: writer FSM states and
// header field layout.
package router_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EMPTY,
    S_LFD,
    S_HDR,
    S_DATA,
    S_DROP,
    S_CHECK
  } state_e;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  localparam int NUM_PORTS = 3;

endpackage

// File: rtl/router_pkt_writer.sv
// Router ingress: decodes the header, streams the packet into the
// addressed FIFO, checks parity and drops bad-address/timed-out packets.
module router_pkt_writer
  import router_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [7:0]           data_in,
  output logic                 busy,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic [7:0]           dout,
  output logic                 pkt_done,
  output logic                 parity_err,
  output logic                 pkt_drop
);

  localparam int CW =
    (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(WAIT_TIMEOUT);

  state_e state_q, state_d;

  logic [7:0]    hdr_q, hdr_d;
  logic [7:0]    par_q, par_d;
  logic [6:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;
  logic          mism_q, mism_d;

  logic [1:0]           addr;
  logic [6:0]           len_hdr;
  logic [6:0]           len_in;
  logic [3:0]           full_x;
  logic [3:0]           empty_x;
  logic                 full_sel;
  logic [NUM_PORTS-1:0] oh;

  assign addr     = hdr_q[ADDR_MSB:ADDR_LSB];
  assign len_hdr  = {1'b0, hdr_q[LEN_MSB:LEN_LSB]} + 7'd1;
  assign len_in   = {1'b0, data_in[LEN_MSB:LEN_LSB]} + 7'd1;
  assign full_x   = {1'b0, fifo_full};
  assign empty_x  = {1'b0, fifo_empty};
  assign full_sel = full_x[addr];
  assign oh       = NUM_PORTS'(1) << addr;

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    par_d      = par_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    mism_d     = mism_q;
    busy       = 1'b0;
    write_enb  = '0;
    lfd_state  = 1'b0;
    dout       = 8'h00;
    pkt_done   = 1'b0;
    parity_err = 1'b0;
    pkt_drop   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pkt_valid) begin
          hdr_d  = data_in;
          par_d  = data_in;
          cnt_d  = '0;
          mism_d = 1'b0;
          drop_d = 1'b0;
          if (data_in[ADDR_MSB:ADDR_LSB] == ADDR_INVALID) begin
            rem_d   = len_in;
            drop_d  = 1'b1;
            state_d = S_DROP;
          end else begin
            state_d = S_WAIT_EMPTY;
          end
        end
      end
      S_WAIT_EMPTY: begin
        busy = 1'b1;
        if (empty_x[addr]) begin
          state_d = S_LFD;
        end else if (WAIT_TIMEOUT != 0 && cnt_q == TMO) begin
          rem_d   = len_hdr;
          drop_d  = 1'b1;
          state_d = S_DROP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LFD: begin
        busy      = 1'b1;
        lfd_state = 1'b1;
        state_d   = S_HDR;
      end
      S_HDR: begin
        busy      = 1'b1;
        write_enb = oh;
        dout      = hdr_q;
        rem_d     = len_hdr;
        state_d   = S_DATA;
      end
      S_DATA: begin
        busy = full_sel;
        dout = data_in;
        if (pkt_valid && !full_sel) begin
          write_enb = oh;
          rem_d     = rem_q - 7'd1;
          // last byte is the parity byte itself, not folded in
          if (rem_q == 7'd1) begin
            mism_d  = (par_q != data_in);
            state_d = S_CHECK;
          end else begin
            par_d = par_q ^ data_in;
          end
        end
      end
      S_DROP: begin
        if (pkt_valid) begin
          rem_d = rem_q - 7'd1;
          if (rem_q == 7'd1) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        busy       = 1'b1;
        pkt_done   = 1'b1;
        pkt_drop   = drop_q;
        parity_err = mism_q && !drop_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      hdr_q   <= 8'h00;
      par_q   <= 8'h00;
      rem_q   <= 7'd0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      par_q   <= par_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      mism_q  <= mism_d;
    end
  end

endmodule

// File: doc/router_pkt_writer.md
Name: router_pkt_writer

Overview:
- Source-side ingress controller of the 1x3 router and the writer for the three per-destination router_fifo instances.
- Accepts a byte-serial packet from the source: header, then payload, then parity.
- Decodes the destination address and streams the header, payload and parity into the selected FIFO. It drives that FIFO's write_enb/lfd_state protocol, honours fifo_full back-pressure and checks packet parity.
- Invalid-address and timed-out packets are consumed and discarded.

Parameters:
- WAIT_TIMEOUT, 0, maximum number of cycles spent waiting for the target FIFO to drain before the packet is dropped. 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- pkt_valid  in  1  source byte valid
- data_in  in  8  source byte
- busy  out  1  not-ready; a byte is accepted iff pkt_valid && !busy
- fifo_full  in  3  full flags of FIFO0..2
- fifo_empty  in  3  empty flags of FIFO0..2
- write_enb  out  3  one-hot FIFO write strobe
- lfd_state  out  1  header marker to all FIFOs
- dout  out  8  write data to all FIFOs
- pkt_done  out  1  one-cycle pulse, packet finished (written or dropped)
- parity_err  out  1  one-cycle pulse with pkt_done; parity mismatch
- pkt_drop  out  1  one-cycle pulse with pkt_done; packet discarded

Behaviour:
- Packet format:
  - Header: [7:2] = LEN (0..63), [1:0] = ADDR (0..2 valid, 3 invalid).
  - Followed by LEN payload bytes, then 1 parity byte.
  - Parity byte = XOR of the header and all payload bytes.
  - Total length is LEN+2 bytes. The FIFO reader expects LEN+1 entries after the header.
- Reset: asynchronous; state IDLE. All outputs 0, except busy, which follows its state rule and is therefore 0. The internal header, length count, parity accumulator and timeout counter are all cleared. A reset mid-packet abandons the packet with no pulse. The source must restart with a header.
- IDLE (busy=0):
  - On acceptance, capture hdr and set par=hdr.
  - If ADDR==3: go to DROP with rem=LEN+1.
  - Otherwise: go to WAIT_EMPTY with the timeout counter cleared.
- WAIT_EMPTY (busy=1):
  - If fifo_empty[ADDR]=1: go to LFD.
  - Otherwise, if WAIT_TIMEOUT!=0 and the counter reaches WAIT_TIMEOUT: go to DROP with rem=LEN+1.
  - Otherwise increment the counter.
- LFD (busy=1): assert lfd_state=1 for exactly this one cycle. No write. Go to HDR. Reason: the FIFO registers lfd_state and applies it to the write on the following edge.
- HDR (busy=1): write_enb[ADDR]=1, dout=hdr, lfd_state=0. The FIFO is empty, so it cannot be full. Set rem=LEN+1. Go to DATA.
- DATA:
  - busy = fifo_full[ADDR]. dout = data_in combinationally.
  - write_enb[ADDR] = pkt_valid && !fifo_full[ADDR]; the other strobes are 0.
  - On each accepted byte, rem decrements. Non-final bytes update par ^= byte.
  - When the byte is accepted with rem==1 (the parity byte), it is written and compared: mismatch = (par != data_in). Go to CHECK.
  - pkt_valid low in DATA: no write, no state change.
  - fifo_full may assert or deassert on any cycle; writes are never issued while it is high.
- DROP (busy=0): accept and discard bytes; write_enb=0. rem decrements per accepted byte. Accepting the byte with rem==1 goes to CHECK with the drop flag set.
- CHECK (busy=1, one cycle):
  - pkt_done=1.
  - pkt_drop=drop flag.
  - parity_err=mismatch && !drop.
  - Go to IDLE.
- Invariants:
  - write_enb is at most one-hot.
  - write_enb and lfd_state never assert in the same cycle.
  - Exactly LEN+2 writes per forwarded packet.
- Width rules: rem is 7 bits and LEN+1 ≤ 64. par is 8 bits. The timeout counter is $clog2(WAIT_TIMEOUT+1) bits, minimum 1.
- Outputs pkt_done, parity_err, pkt_drop and lfd_state are decoded from registered state. busy, write_enb and dout are combinational from state, pkt_valid, data_in and fifo_full.

Decomposition:
- Shared package router_pkg holds:
  - the state encoding (IDLE, WAIT_EMPTY, LFD, HDR, DATA, DROP, CHECK);
  - ADDR_INVALID=2'b11;
  - the header field positions LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0;
  - NUM_PORTS=3.
- No sub-module: a single FSM with its datapath registers.

Test Plan:
- Forward: resetn pulse, then header 8'h0D (LEN=3, ADDR=1), payload 11,22,33 and parity 8'h0D^11^22^33, all FIFOs empty.
  - lfd_state high one cycle, then write_enb=3'b010 for 5 writes.
  - pkt_done pulses; parity_err=0; busy=0 thereafter.
- Parity error: as above with parity byte XOR 8'h01 → all 5 bytes written; pkt_done=1 and parity_err=1 in the same cycle.
- Invalid address: header 8'h07 (LEN=1, ADDR=3) plus 2 bytes → no write_enb. pkt_done=1, pkt_drop=1 after the 3rd byte.
- Back-pressure: fifo_full[0] forced high for 4 cycles mid-payload of an ADDR=0 packet.
  - busy=1 and write_enb=0 during the stall.
  - Writes resume, and the byte held on data_in is written exactly once.
- Wait and timeout, ADDR=2 with fifo_empty[2]=0:
  - With WAIT_TIMEOUT=0: busy stays 1 until fifo_empty[2] rises, then the LFD and HDR sequence runs.
  - With WAIT_TIMEOUT=5: the packet is dropped after 5 cycles; pkt_drop=1 after the remaining LEN+1 bytes.
- Async reset mid-DATA: resetn low between edges → all outputs 0 immediately. A new packet is then forwarded correctly.
